// File: rtl/cr16_pkg.sv
// Shared CR16 constants: PSR flag bit positions and condition-code encodings.
// Imported by the ALU, the decoder and the PSR/condition logic.
package cr16_pkg;

    localparam int unsigned PSR_W = 5;

    localparam int unsigned STATUS_INDEX_CARRY    = 0;
    localparam int unsigned STATUS_INDEX_LOW      = 1;
    localparam int unsigned STATUS_INDEX_FLAG     = 2;
    localparam int unsigned STATUS_INDEX_ZERO     = 3;
    localparam int unsigned STATUS_INDEX_NEGATIVE = 4;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_HI = 4'h4;
    localparam logic [3:0] COND_LS = 4'h5;
    localparam logic [3:0] COND_GT = 4'h6;
    localparam logic [3:0] COND_LE = 4'h7;
    localparam logic [3:0] COND_FS = 4'h8;
    localparam logic [3:0] COND_FC = 4'h9;
    localparam logic [3:0] COND_LO = 4'hA;
    localparam logic [3:0] COND_HS = 4'hB;
    localparam logic [3:0] COND_LT = 4'hC;
    localparam logic [3:0] COND_GE = 4'hD;
    localparam logic [3:0] COND_UC = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/cr16_cond_eval.sv
// Combinational CR16 condition evaluator: (PSR flags, 4-bit condition) -> true.
// Shared by the branch/jump path and the Scond path.
module cr16_cond_eval
    import cr16_pkg::*;
(
    input  logic [PSR_W-1:0] flags_i,
    input  logic [3:0]       cond_i,
    output logic             true_o
);

    logic c, l, f, z, n;

    assign c = flags_i[STATUS_INDEX_CARRY];
    assign l = flags_i[STATUS_INDEX_LOW];
    assign f = flags_i[STATUS_INDEX_FLAG];
    assign z = flags_i[STATUS_INDEX_ZERO];
    assign n = flags_i[STATUS_INDEX_NEGATIVE];

    always_comb begin
        true_o = 1'b0;
        unique case (cond_i)
            COND_EQ: true_o = z;
            COND_NE: true_o = ~z;
            COND_CS: true_o = c;
            COND_CC: true_o = ~c;
            COND_HI: true_o = l;
            COND_LS: true_o = ~l;
            COND_GT: true_o = n;
            COND_LE: true_o = ~n;
            COND_FS: true_o = f;
            COND_FC: true_o = ~f;
            COND_LO: true_o = ~l & ~z;
            COND_HS: true_o = l | z;
            COND_LT: true_o = ~n & ~z;
            COND_GE: true_o = n | z;
            COND_UC: true_o = 1'b1;
            COND_NV: true_o = 1'b0;
            default: true_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cr16_psr_cond.sv
// CR16 processor status register: captures ALU flags, keeps a one-deep interrupt shadow,
// and returns registered condition-code results one cycle after each query.
module cr16_psr_cond
    import cr16_pkg::*;
#(
    parameter logic [PSR_W-1:0] RESET_FLAGS = 5'b00000,
    parameter bit               FORWARD     = 1'b1
) (
    input  logic             I_CLK,
    input  logic             I_NRESET,
    input  logic             I_STATUS_WE,
    input  logic [PSR_W-1:0] I_STATUS,
    input  logic [PSR_W-1:0] I_STATUS_MASK,
    input  logic             I_SAVE,
    input  logic             I_RESTORE,
    input  logic             I_COND_VALID,
    input  logic [3:0]       I_COND,
    output logic [PSR_W-1:0] O_FLAGS,
    output logic             O_COND_VALID,
    output logic             O_COND_TRUE,
    output logic             O_SHADOW_VALID,
    output logic             O_RESTORE_ERR
);

    logic [PSR_W-1:0] flags_d, flags_q;
    logic [PSR_W-1:0] shadow_d, shadow_q;
    logic             shadow_valid_d, shadow_valid_q;
    logic             cond_valid_d, cond_valid_q;
    logic             cond_true_d, cond_true_q;
    logic             restore_err_d, restore_err_q;
    logic             restore_hit;
    logic [PSR_W-1:0] eval_flags;
    logic             eval_true;

    assign restore_hit = I_RESTORE & shadow_valid_q;

    // A successful restore overrides any same-cycle status write.
    always_comb begin
        flags_d = flags_q;
        if (restore_hit) begin
            flags_d = shadow_q;
        end else if (I_STATUS_WE) begin
            flags_d = (flags_q & ~I_STATUS_MASK) | (I_STATUS & I_STATUS_MASK);
        end
    end

    always_comb begin
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        if (restore_hit) begin
            shadow_valid_d = 1'b0;
        end else if (I_SAVE && !I_RESTORE) begin
            shadow_d       = flags_d;
            shadow_valid_d = 1'b1;
        end
    end

    assign eval_flags = FORWARD ? flags_d : flags_q;

    cr16_cond_eval u_cond_eval (
        .flags_i (eval_flags),
        .cond_i  (I_COND),
        .true_o  (eval_true)
    );

    always_comb begin
        cond_valid_d  = I_COND_VALID;
        cond_true_d   = I_COND_VALID ? eval_true : cond_true_q;
        restore_err_d = I_RESTORE & ~shadow_valid_q;
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            flags_q        <= RESET_FLAGS;
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
            cond_valid_q   <= 1'b0;
            cond_true_q    <= 1'b0;
            restore_err_q  <= 1'b0;
        end else begin
            flags_q        <= flags_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
            cond_valid_q   <= cond_valid_d;
            cond_true_q    <= cond_true_d;
            restore_err_q  <= restore_err_d;
        end
    end

    assign O_FLAGS        = flags_q;
    assign O_COND_VALID   = cond_valid_q;
    assign O_COND_TRUE    = cond_true_q;
    assign O_SHADOW_VALID = shadow_valid_q;
    assign O_RESTORE_ERR  = restore_err_q;

endmodule

// File: tb/tb_cr16_psr_cond.sv
// Bench for cr16_psr_cond: a forwarding and a non-forwarding instance share one stimulus.
module tb_cr16_psr_cond;

    logic       clk;
    logic       nreset;
    logic       status_we;
    logic [4:0] status;
    logic [4:0] status_mask;
    logic       save;
    logic       restore;
    logic       cond_valid;
    logic [3:0] cond;

    logic [4:0] fw_flags, nf_flags;
    logic       fw_cv, nf_cv, fw_ct, nf_ct, fw_sv, nf_sv, fw_err, nf_err;

    int checks   = 0;
    int failures = 0;

    cr16_psr_cond #(.RESET_FLAGS(5'b00000), .FORWARD(1'b1)) u_dut_fw (
        .I_CLK          (clk),
        .I_NRESET       (nreset),
        .I_STATUS_WE    (status_we),
        .I_STATUS       (status),
        .I_STATUS_MASK  (status_mask),
        .I_SAVE         (save),
        .I_RESTORE      (restore),
        .I_COND_VALID   (cond_valid),
        .I_COND         (cond),
        .O_FLAGS        (fw_flags),
        .O_COND_VALID   (fw_cv),
        .O_COND_TRUE    (fw_ct),
        .O_SHADOW_VALID (fw_sv),
        .O_RESTORE_ERR  (fw_err)
    );

    cr16_psr_cond #(.RESET_FLAGS(5'b00000), .FORWARD(1'b0)) u_dut_nf (
        .I_CLK          (clk),
        .I_NRESET       (nreset),
        .I_STATUS_WE    (status_we),
        .I_STATUS       (status),
        .I_STATUS_MASK  (status_mask),
        .I_SAVE         (save),
        .I_RESTORE      (restore),
        .I_COND_VALID   (cond_valid),
        .I_COND         (cond),
        .O_FLAGS        (nf_flags),
        .O_COND_VALID   (nf_cv),
        .O_COND_TRUE    (nf_ct),
        .O_SHADOW_VALID (nf_sv),
        .O_RESTORE_ERR  (nf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per condition code: bit v of mask is the expected result when PSR == v.
    typedef struct {
        logic [3:0]  code;
        logic [31:0] mask;
    } cond_vec_t;

    cond_vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        status_we   = 1'b0;
        status      = 5'b0;
        status_mask = 5'b0;
        save        = 1'b0;
        restore     = 1'b0;
        cond_valid  = 1'b0;
        cond        = 4'h0;
    endtask

    task automatic write_psr(input logic [4:0] v);
        idle();
        status_we   = 1'b1;
        status      = v;
        status_mask = 5'b11111;
        step();
        idle();
    endtask

    initial begin
        vecs[0]  = '{4'h0, 32'hFF00FF00};
        vecs[1]  = '{4'h1, 32'h00FF00FF};
        vecs[2]  = '{4'h2, 32'hAAAAAAAA};
        vecs[3]  = '{4'h3, 32'h55555555};
        vecs[4]  = '{4'h4, 32'hCCCCCCCC};
        vecs[5]  = '{4'h5, 32'h33333333};
        vecs[6]  = '{4'h6, 32'hFFFF0000};
        vecs[7]  = '{4'h7, 32'h0000FFFF};
        vecs[8]  = '{4'h8, 32'hF0F0F0F0};
        vecs[9]  = '{4'h9, 32'h0F0F0F0F};
        vecs[10] = '{4'hA, 32'h00330033};
        vecs[11] = '{4'hB, 32'hFFCCFFCC};
        vecs[12] = '{4'hC, 32'h000000FF};
        vecs[13] = '{4'hD, 32'hFFFFFF00};
        vecs[14] = '{4'hE, 32'hFFFFFFFF};
        vecs[15] = '{4'hF, 32'h00000000};

        idle();
        nreset = 1'b0;
        step();
        step();
        chk("reset_flags", 32'(fw_flags), 32'h0);
        chk("reset_cond_valid", 32'(fw_cv), 32'h0);
        chk("reset_cond_true", 32'(fw_ct), 32'h0);
        chk("reset_shadow_valid", 32'(fw_sv), 32'h0);
        chk("reset_restore_err", 32'(nf_err), 32'h0);
        nreset = 1'b1;
        step();

        // Always / never queries, then hold of the last result
        cond_valid = 1'b1;
        cond       = 4'hF;
        step();
        chk("nv_valid", 32'(fw_cv), 32'h1);
        chk("nv_true", 32'(fw_ct), 32'h0);
        cond = 4'hE;
        step();
        chk("uc_valid", 32'(nf_cv), 32'h1);
        chk("uc_true", 32'(nf_ct), 32'h1);
        cond_valid = 1'b0;
        cond       = 4'hF;
        step();
        chk("hold_valid", 32'(fw_cv), 32'h0);
        chk("hold_true", 32'(fw_ct), 32'h1);

        // Same-cycle write and EQ query: only the forwarding instance sees Z
        idle();
        status_we   = 1'b1;
        status      = 5'b01000;
        status_mask = 5'b11111;
        cond_valid  = 1'b1;
        cond        = 4'h0;
        step();
        idle();
        chk("fwd_eq_true", 32'(fw_ct), 32'h1);
        chk("nofwd_eq_true", 32'(nf_ct), 32'h0);
        chk("fwd_flags", 32'(fw_flags), 32'h08);
        chk("nofwd_flags", 32'(nf_flags), 32'h08);

        // Masked write touches only C
        write_psr(5'b11111);
        status_we   = 1'b1;
        status      = 5'b00000;
        status_mask = 5'b00001;
        step();
        idle();
        chk("masked_flags", 32'(fw_flags), 32'h1E);
        cond_valid = 1'b1;
        cond       = 4'h3;
        step();
        idle();
        chk("cc_fwd", 32'(fw_ct), 32'h1);
        chk("cc_nofwd", 32'(nf_ct), 32'h1);

        // Save, overwrite, restore with a discarded same-cycle write
        write_psr(5'b00010);
        save = 1'b1;
        step();
        idle();
        chk("save_valid", 32'(fw_sv), 32'h1);
        write_psr(5'b00000);
        chk("pre_restore_flags", 32'(fw_flags), 32'h0);
        restore     = 1'b1;
        status_we   = 1'b1;
        status      = 5'b11111;
        status_mask = 5'b11111;
        step();
        idle();
        chk("restore_flags", 32'(fw_flags), 32'h02);
        chk("restore_shadow_valid", 32'(fw_sv), 32'h0);
        chk("restore_no_err", 32'(fw_err), 32'h0);

        // Restore without shadow; same-cycle save must be ignored
        restore = 1'b1;
        save    = 1'b1;
        step();
        idle();
        chk("err_pulse", 32'(fw_err), 32'h1);
        chk("err_flags", 32'(fw_flags), 32'h02);
        chk("err_save_ignored", 32'(nf_sv), 32'h0);
        step();
        chk("err_clear", 32'(fw_err), 32'h0);

        // Sweep all codes against all PSR values, with a reset dropped in mid-sweep
        for (int v = 0; v < 32; v++) begin
            write_psr(5'(v));
            for (int k = 0; k < 16; k++) begin
                cond_valid = 1'b1;
                cond       = vecs[k].code;
                step();
                chk($sformatf("sweep_fw c%0h f%0d", vecs[k].code, v), 32'(fw_ct),
                    32'(vecs[k].mask[v]));
                chk($sformatf("sweep_nf c%0h f%0d", vecs[k].code, v), 32'(nf_ct),
                    32'(vecs[k].mask[v]));
            end
            idle();
            if (v == 16) begin
                cond_valid = 1'b1;
                cond       = 4'hE;
                step();
                idle();
                chk("midq_valid", 32'(fw_cv), 32'h1);
                #2;
                nreset = 1'b0;
                #1;
                chk("async_cv_fw", 32'(fw_cv), 32'h0);
                chk("async_cv_nf", 32'(nf_cv), 32'h0);
                chk("async_flags", 32'(fw_flags), 32'h0);
                step();
                nreset = 1'b1;
                step();
                chk("post_reset_cv", 32'(fw_cv), 32'h0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
